// File: rtl/present_ctrl.sv
// present_ctrl: command front-end and round sequencer for a PRESENT-80 datapath.
// Decodes the pl/in command bus, keeps the key, a plaintext register and a
// one-deep pending-start buffer, and walks the external round core through
// LOAD, ROUNDS round cycles and ciphertext capture.
// Optional build macro: PRESENT_CTRL_ASSERT_EN compiles in interface/protocol
// assertions; the default build leaves them out and behaves identically.
module present_ctrl #(
    parameter int ROUNDS = 31,
    parameter int KEY_W  = 80,
    parameter int BLK_W  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       pl,
    input  logic [KEY_W-1:0] in,
    output logic             core_ld,
    output logic [KEY_W-1:0] core_key,
    output logic [BLK_W-1:0] core_pt,
    output logic             core_round_en,
    output logic [4:0]       core_round,
    input  logic [BLK_W-1:0] core_ct,
    output logic [BLK_W-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             cmd_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [4:0] ROUNDS_C = 5'(ROUNDS);

    state_t             r_state;
    logic [KEY_W-1:0]   r_key;
    logic               r_key_vld;
    logic [BLK_W-1:0]   r_data;
    logic [BLK_W-1:0]   r_pend_pt;
    logic               r_pend_vld;
    logic               r_ld_pend;
    logic [KEY_W-1:0]   r_key_hold;
    logic [BLK_W-1:0]   r_pt_hold;

    logic               w_cmd_key;
    logic               w_cmd_pt;
    logic               w_cmd_start;
    logic [BLK_W-1:0]   w_in_pt;
    logic [BLK_W-1:0]   w_ld_pt;

    assign w_cmd_key   = (pl == 2'b01);
    assign w_cmd_pt    = (pl == 2'b10);
    assign w_cmd_start = (pl == 2'b11);
    assign w_in_pt     = in[BLK_W-1:0];

    // A block leaving IDLE takes data_reg; a block launched from DONE takes
    // the pending buffer (which also receives a start arriving during DONE).
    assign w_ld_pt = r_ld_pend ? r_pend_pt : r_data;

    // During LOAD the core sees the live key/plaintext registers, so a key
    // loaded while the previous block was finishing is picked up; otherwise
    // the last presented values are held.
    assign core_key = core_ld ? r_key   : r_key_hold;
    assign core_pt  = core_ld ? w_ld_pt : r_pt_hold;

    // Key and plaintext registers: load commands are accepted in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key     <= '0;
            r_key_vld <= 1'b0;
            r_data    <= '0;
        end else begin
            if (w_cmd_key) begin
                r_key     <= in;
                r_key_vld <= 1'b1;
            end
            if (w_cmd_pt || w_cmd_start) begin
                r_data <= w_in_pt;
            end
        end
    end

    // Capture what was presented at LOAD so the core-facing buses stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_hold <= '0;
            r_pt_hold  <= '0;
        end else if (core_ld) begin
            r_key_hold <= r_key;
            r_pt_hold  <= w_ld_pt;
        end
    end

    // Sequencer FSM with pending-start handling and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pend_pt     <= '0;
            r_pend_vld    <= 1'b0;
            r_ld_pend     <= 1'b0;
            core_ld       <= 1'b0;
            core_round_en <= 1'b0;
            core_round    <= 5'd0;
            dout          <= '0;
            dout_valid    <= 1'b0;
            busy          <= 1'b0;
            cmd_err       <= 1'b0;
        end else begin
            core_ld    <= 1'b0;
            dout_valid <= 1'b0;
            cmd_err    <= 1'b0;

            // Starts outside IDLE queue one block; a second one is dropped.
            if (w_cmd_start && (r_state != S_IDLE)) begin
                if (!r_pend_vld) begin
                    r_pend_pt  <= w_in_pt;
                    r_pend_vld <= 1'b1;
                end else begin
                    cmd_err <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_cmd_start) begin
                        if (r_key_vld) begin
                            r_state   <= S_LOAD;
                            core_ld   <= 1'b1;
                            busy      <= 1'b1;
                            r_ld_pend <= 1'b0;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    r_state       <= S_ROUND;
                    core_round    <= 5'd1;
                    core_round_en <= 1'b1;
                end

                S_ROUND: begin
                    if (core_round == ROUNDS_C) begin
                        r_state       <= S_DONE;
                        core_round_en <= 1'b0;
                    end else begin
                        core_round <= core_round + 5'd1;
                    end
                end

                S_DONE: begin
                    dout       <= core_ct;
                    dout_valid <= 1'b1;
                    core_round <= 5'd0;
                    // A start seen in this very cycle lands in the pending
                    // buffer above and is serviced straight away.
                    if (r_pend_vld || w_cmd_start) begin
                        r_state    <= S_LOAD;
                        core_ld    <= 1'b1;
                        r_ld_pend  <= 1'b1;
                        r_pend_vld <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PRESENT_CTRL_ASSERT_EN
    a_pl_known: assert property (@(negedge clk) disable iff (!rst_n)
        !$isunknown(pl));
    a_in_known: assert property (@(negedge clk) disable iff (!rst_n)
        (pl != 2'b00) |-> !$isunknown(in));
    a_ct_known: assert property (@(negedge clk) disable iff (!rst_n)
        (r_state == S_DONE) |-> !$isunknown(core_ct));
    a_ld_round_excl: assert property (@(negedge clk) disable iff (!rst_n)
        !(core_ld && core_round_en));
    a_dv_pulse: assert property (@(negedge clk) disable iff (!rst_n)
        dout_valid |=> !dout_valid);
`else
    // Assertions are not built in this configuration.
`endif

endmodule

// File: tb/tb_present_ctrl.sv
// Self-checking bench for present_ctrl. Includes a behavioural PRESENT-80
// round core driven by the controller and a whole-block reference cipher
// used for expected ciphertexts. Cycle number k is the clock period that
// starts at rising edge k-1; a command driven in cycle t is sampled at edge t.
module tb_present_ctrl;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  pl    = 2'b00;
    logic [79:0] din   = '0;

    logic        core_ld, core_round_en, dout_valid, busy, cmd_err;
    logic [79:0] core_key;
    logic [63:0] core_pt, core_ct, dout;
    logic [4:0]  core_round;

    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;

    int          v_cyc[$];
    logic [63:0] v_dat[$];
    int          e_cyc[$];

    logic [63:0] m_st = '0;
    logic [79:0] m_k  = '0;

    always #5 clk = ~clk;

    present_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pl            (pl),
        .in            (din),
        .core_ld       (core_ld),
        .core_key      (core_key),
        .core_pt       (core_pt),
        .core_round_en (core_round_en),
        .core_round    (core_round),
        .core_ct       (core_ct),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .busy          (busy),
        .cmd_err       (cmd_err)
    );

    // ---------------- PRESENT-80 primitives ----------------
    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] s);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox4(s[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] s);
        logic [63:0] r;
        for (int i = 0; i < 63; i++) r[(i * 16) % 63] = s[i];
        r[63] = s[63];
        return r;
    endfunction

    function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] n;
        n = {k[18:0], k[79:19]};
        n[79:76] = sbox4(n[79:76]);
        n[19:15] = n[19:15] ^ rc;
        return n;
    endfunction

    function automatic logic [63:0] present_enc(input logic [79:0] key, input logic [63:0] pt);
        logic [63:0] st;
        logic [79:0] k;
        st = pt;
        k  = key;
        for (int r = 1; r <= 31; r++) begin
            st = p_layer(sbox_layer(st ^ k[79:16]));
            k  = key_upd(k, 5'(r));
        end
        return st ^ k[79:16];
    endfunction

    function automatic logic [79:0] rand80();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[79:0];
    endfunction

    // ---------------- external round core model ----------------
    always @(posedge clk) begin
        if (core_ld) begin
            m_st <= core_pt;
            m_k  <= core_key;
        end else if (core_round_en) begin
            m_st <= p_layer(sbox_layer(m_st ^ m_k[79:16]));
            m_k  <= key_upd(m_k, core_round);
        end
    end
    assign core_ct = m_st ^ m_k[79:16];

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: records cycle numbers of dout_valid and cmd_err pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_valid) begin
                v_cyc.push_back(cyc + 1);
                v_dat.push_back(dout);
            end
            if (cmd_err) e_cyc.push_back(cyc + 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_q();
        v_cyc.delete();
        v_dat.delete();
        e_cyc.delete();
    endtask

    // Drive one command in the current cycle; t is the cycle number it is driven in.
    task automatic cmd(input logic [1:0] p, input logic [79:0] d, output int t);
        pl  = p;
        din = d;
        t   = cyc + 1;
        @(negedge clk);
        pl  = 2'b00;
        din = '0;
    endtask

    task automatic wait_cycle(input int c);
        while (cyc + 1 < c) @(negedge clk);
    endtask

    task automatic wait_valid(input int n, input int budget);
        int i;
        i = 0;
        while (v_cyc.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_q();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if (core_ld !== 1'b0 || core_round_en !== 1'b0) begin n_err++; $display("FAIL reset_core_ctl: got ld=%b en=%b want 0 0", core_ld, core_round_en); end
        n_chk++; if (core_round !== 5'd0) begin n_err++; $display("FAIL reset_round: got %0d want 0", core_round); end
        n_chk++; if (dout !== 64'h0 || dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_dout: got %h/%b want 0/0", dout, dout_valid); end
        n_chk++; if (cmd_err !== 1'b0) begin n_err++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err); end
        n_chk++; if (core_key !== 80'h0 || core_pt !== 64'h0) begin n_err++; $display("FAIL reset_core_bus: got %h/%h want 0/0", core_key, core_pt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_q();
    endtask

    task automatic test_no_key();
        int t;
        bit busy_seen;
        busy_seen = 1'b0;
        clear_q();
        cmd(2'b11, rand80(), t);
        repeat (40) begin
            if (busy !== 1'b0) busy_seen = 1'b1;
            @(negedge clk);
        end
        n_chk++; if (e_cyc.size() != 1) begin n_err++; $display("FAIL nokey_err_count: got %0d want 1", e_cyc.size()); end
        else begin
            n_chk++; if (e_cyc[0] != t + 1) begin n_err++; $display("FAIL nokey_err_cycle: got %0d want %0d", e_cyc[0], t + 1); end
        end
        n_chk++; if (busy_seen) begin n_err++; $display("FAIL nokey_busy: got 1 want 0"); end
        n_chk++; if (v_cyc.size() != 0) begin n_err++; $display("FAIL nokey_valid: got %0d strobes want 0", v_cyc.size()); end
    endtask

    task automatic test_known_vector(input logic [79:0] k, input logic [63:0] p,
                                     input logic [63:0] exp_ct, input string nm);
        int t;
        int d;
        clear_q();
        cmd(2'b01, k, d);
        cmd(2'b11, {16'hA5C3, p}, t);
        // now in cycle t+1 (LOAD)
        n_chk++; if (busy !== 1'b1 || core_ld !== 1'b1) begin n_err++; $display("FAIL %s_load: got busy=%b ld=%b want 1 1", nm, busy, core_ld); end
        n_chk++; if (core_key !== k || core_pt !== p) begin n_err++; $display("FAIL %s_load_bus: got %h/%h want %h/%h", nm, core_key, core_pt, k, p); end
        @(negedge clk);
        n_chk++; if (core_round !== 5'd1 || core_round_en !== 1'b1 || core_ld !== 1'b0) begin n_err++; $display("FAIL %s_round1: got r=%0d en=%b ld=%b want 1 1 0", nm, core_round, core_round_en, core_ld); end
        wait_cycle(t + 32);
        n_chk++; if (core_round !== 5'd31 || core_round_en !== 1'b1) begin n_err++; $display("FAIL %s_round31: got r=%0d en=%b want 31 1", nm, core_round, core_round_en); end
        @(negedge clk);
        n_chk++; if (core_round_en !== 1'b0 || busy !== 1'b1 || dout_valid !== 1'b0) begin n_err++; $display("FAIL %s_done: got en=%b busy=%b dv=%b want 0 1 0", nm, core_round_en, busy, dout_valid); end
        @(negedge clk);
        n_chk++; if (dout_valid !== 1'b1 || dout !== exp_ct) begin n_err++; $display("FAIL %s_ct: got dv=%b dout=%h want 1 %h", nm, dout_valid, dout, exp_ct); end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_busy_fall: got %b want 0", nm, busy); end
        @(negedge clk);
        n_chk++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL %s_dv_pulse: got %b want 0", nm, dout_valid); end
    endtask

    task automatic test_random();
        int t;
        int d;
        logic [79:0] k;
        logic [79:0] raw;
        for (int it = 0; it < 3; it++) begin
            clear_q();
            k   = rand80();
            raw = rand80();
            cmd(2'b01, k, d);
            cmd(2'b11, raw, t);
            wait_cycle(t + 8);
            cmd(2'b10, rand80(), d);
            wait_cycle(t + 20);
            cmd(2'b01, rand80(), d);
            wait_valid(1, 60);
            n_chk++; if (v_cyc.size() != 1) begin n_err++; $display("FAIL rand%0d_count: got %0d want 1", it, v_cyc.size()); end
            else begin
                n_chk++; if (v_cyc[0] != t + 34) begin n_err++; $display("FAIL rand%0d_latency: got %0d want %0d", it, v_cyc[0], t + 34); end
                n_chk++; if (v_dat[0] !== present_enc(k, raw[63:0])) begin n_err++; $display("FAIL rand%0d_ct: got %h want %h", it, v_dat[0], present_enc(k, raw[63:0])); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ta, tb, tc, d;
        logic [79:0] k;
        logic [63:0] pa, pb;
        clear_q();
        k  = rand80();
        pa = rand80()[63:0];
        pb = rand80()[63:0];
        cmd(2'b01, k, d);
        cmd(2'b11, {16'h0, pa}, ta);
        wait_cycle(ta + 5);
        cmd(2'b11, {16'hFFFF, pb}, tb);
        wait_cycle(ta + 10);
        cmd(2'b11, rand80(), tc);
        wait_valid(2, 100);
        n_chk++; if (v_cyc.size() != 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", v_cyc.size()); end
        else begin
            n_chk++; if (v_cyc[0] != ta + 34) begin n_err++; $display("FAIL b2b_a_latency: got %0d want %0d", v_cyc[0], ta + 34); end
            n_chk++; if (v_cyc[1] != v_cyc[0] + 33) begin n_err++; $display("FAIL b2b_spacing: got %0d want %0d", v_cyc[1], v_cyc[0] + 33); end
            n_chk++; if (v_dat[0] !== present_enc(k, pa)) begin n_err++; $display("FAIL b2b_a_ct: got %h want %h", v_dat[0], present_enc(k, pa)); end
            n_chk++; if (v_dat[1] !== present_enc(k, pb)) begin n_err++; $display("FAIL b2b_b_ct: got %h want %h", v_dat[1], present_enc(k, pb)); end
        end
        n_chk++; if (e_cyc.size() != 1) begin n_err++; $display("FAIL b2b_err_count: got %0d want 1", e_cyc.size()); end
        else begin
            n_chk++; if (e_cyc[0] != tc + 1) begin n_err++; $display("FAIL b2b_err_cycle: got %0d want %0d", e_cyc[0], tc + 1); end
        end
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_done_start();
        int ta, tb, d;
        logic [79:0] k;
        logic [63:0] pa, pb;
        clear_q();
        k  = rand80();
        pa = rand80()[63:0];
        pb = rand80()[63:0];
        cmd(2'b01, k, d);
        cmd(2'b11, {16'h0, pa}, ta);
        wait_cycle(ta + 33);
        cmd(2'b11, {16'h0, pb}, tb);
        n_chk++; if (core_ld !== 1'b1) begin n_err++; $display("FAIL done_start_load: got ld=%b want 1", core_ld); end
        wait_valid(2, 100);
        n_chk++; if (v_cyc.size() != 2) begin n_err++; $display("FAIL done_start_count: got %0d want 2", v_cyc.size()); end
        else begin
            n_chk++; if (v_cyc[1] != ta + 67) begin n_err++; $display("FAIL done_start_latency: got %0d want %0d", v_cyc[1], ta + 67); end
            n_chk++; if (v_dat[1] !== present_enc(k, pb)) begin n_err++; $display("FAIL done_start_ct: got %h want %h", v_dat[1], present_enc(k, pb)); end
        end
        n_chk++; if (e_cyc.size() != 0) begin n_err++; $display("FAIL done_start_err: got %0d pulses want 0", e_cyc.size()); end
    endtask

    task automatic test_key_change();
        int ta, tb, d;
        logic [79:0] k1, k2;
        logic [63:0] pa, pb;
        clear_q();
        k1 = rand80();
        k2 = rand80();
        pa = rand80()[63:0];
        pb = rand80()[63:0];
        cmd(2'b01, k1, d);
        cmd(2'b11, {16'h0, pa}, ta);
        wait_cycle(ta + 5);
        cmd(2'b11, {16'h0, pb}, tb);
        wait_cycle(ta + 11);
        n_chk++; if (core_round !== 5'd10) begin n_err++; $display("FAIL keychg_round: got %0d want 10", core_round); end
        cmd(2'b01, k2, d);
        wait_valid(2, 100);
        n_chk++; if (v_cyc.size() != 2) begin n_err++; $display("FAIL keychg_count: got %0d want 2", v_cyc.size()); end
        else begin
            n_chk++; if (v_dat[0] !== present_enc(k1, pa)) begin n_err++; $display("FAIL keychg_a_ct: got %h want %h", v_dat[0], present_enc(k1, pa)); end
            n_chk++; if (v_dat[1] !== present_enc(k2, pb)) begin n_err++; $display("FAIL keychg_b_ct: got %h want %h", v_dat[1], present_enc(k2, pb)); end
        end
    endtask

    task automatic test_reset_mid();
        int t, d;
        clear_q();
        cmd(2'b01, rand80(), d);
        cmd(2'b11, rand80(), t);
        wait_cycle(t + 16);
        n_chk++; if (core_round !== 5'd15) begin n_err++; $display("FAIL rstmid_round: got %0d want 15", core_round); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0 || core_round_en !== 1'b0 || core_round !== 5'd0 || core_ld !== 1'b0) begin n_err++; $display("FAIL rstmid_ctl: got busy=%b en=%b r=%0d ld=%b want 0 0 0 0", busy, core_round_en, core_round, core_ld); end
        n_chk++; if (dout !== 64'h0 || dout_valid !== 1'b0 || cmd_err !== 1'b0) begin n_err++; $display("FAIL rstmid_out: got %h/%b/%b want 0/0/0", dout, dout_valid, cmd_err); end
        n_chk++; if (core_key !== 80'h0 || core_pt !== 64'h0) begin n_err++; $display("FAIL rstmid_bus: got %h/%h want 0/0", core_key, core_pt); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        n_chk++; if (v_cyc.size() != 0) begin n_err++; $display("FAIL rstmid_valid: got %0d strobes want 0", v_cyc.size()); end
        cmd(2'b11, rand80(), t);
        repeat (3) @(negedge clk);
        n_chk++; if (e_cyc.size() != 1) begin n_err++; $display("FAIL rstmid_err_count: got %0d want 1", e_cyc.size()); end
        else begin
            n_chk++; if (e_cyc[0] != t + 1) begin n_err++; $display("FAIL rstmid_err_cycle: got %0d want %0d", e_cyc[0], t + 1); end
        end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_no_key();
        test_known_vector(80'h0, 64'h0, 64'h5579C1387B228445, "vec0");
        test_known_vector(80'hFFFF_FFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3333DCD3213210D2, "vec1");
        test_random();
        test_back_to_back();
        test_done_start();
        test_key_change();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
